matmul5_seq: RTL and testbench
==============================

Name: matmul5_seq

Overview:
- Sequencer upstream of the 8-bit signed MAC unit.
- Snapshots two packed 5x5 int8 matrices A and B.
- Walks the 25 output elements of C = A x B in row-major order. For each element it presents row i of A and column j of B to the MAC, enables it, and waits for the MAC's done.
- Writes each result into a packed 5x5 C buffer and aggregates overflow.
- Acts as the matrix-level front end between the HPS register interface and the MAC.

Parameters:
DIM, 5, matrix dimension; fixed at 5 to match the 40-bit MAC operand width (other values unsupported).
W, 8, element width in bits, two's complement.
TIMEOUT, 16, maximum WAIT cycles per element before abort.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  begin multiplication; sampled only in IDLE.
mat_a  in  200  matrix A; element (r,c) at bits [8*(5r+c)+7 : 8*(5r+c)].
mat_b  in  200  matrix B; same packing.
mac_a  out  40  row i of A; lane k (bits 8k+7:8k) = A(i,k).
mac_b  out  40  column j of B; lane k = B(k,j).
mac_en  out  1  MAC enable.
mac_result  in  8  MAC accumulated result.
mac_overflow  in  1  MAC overflow flag.
mac_done  in  1  MAC completion pulse.
mat_c  out  200  result matrix C; same packing as mat_a.
ovf_map  out  25  per-element overflow; bit 5i+j.
ovf  out  1  OR of ovf_map.
err  out  1  watchdog abort flag.
busy  out  1  high in any state other than IDLE.
done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State goes to IDLE; i, j and the watchdog clear to 0; snapshots clear.
  - mat_c, ovf_map, ovf, err, busy, done, mac_en, mac_a and mac_b are all 0.
  - Reset takes effect immediately, including mid-run; the run is abandoned with no done pulse.
- All outputs are driven from registers or from decode of registered state only. There is no combinational path from mat_a, mat_b or the mac_* inputs to any output.
- IDLE:
  - On start=1: snapshot mat_a/mat_b into internal registers, clear mat_c, ovf_map and err, set i=j=0, go to SETUP.
  - Otherwise stay in IDLE.
- SETUP (1 cycle):
  - mac_en=0; mac_a and mac_b reflect the current (i,j) from the snapshots.
  - Clear the watchdog; go to WAIT.
  - The mac_en=0 cycle doubles as the MAC's internal reset/clear cycle between elements.
- WAIT:
  - mac_en=1; mac_a and mac_b are held stable; the watchdog increments each cycle.
  - If mac_done=1: on that edge write mac_result into C(i,j) and mac_overflow into ovf_map[5i+j].
    - If (i,j)=(4,4), go to FINISH.
    - Else j=j+1, wrapping to 0 with i=i+1 when j=4, and go to SETUP.
  - Else if the watchdog reaches TIMEOUT-1 with mac_done=0: set err=1 and go to FINISH. Already-written elements are kept; the rest stay 0.
- FINISH (1 cycle): done=1, busy=1, mac_en=0; then go to IDLE.
- mac_done outside WAIT is ignored. start outside IDLE (including FINISH) is ignored.
- Changes to mat_a/mat_b after start has been accepted have no effect on the run.
- ovf = |ovf_map, registered; it and err hold their values until the next accepted start or reset.
- Latency: with a MAC raising done on its 6th enabled cycle (L=6), each element takes 1+L = 7 cycles. done is high in the cycle following the 175th rising edge after the edge that accepted start.
- This block performs no arithmetic on data; results are stored exactly as mac_result (8-bit two's complement, wrapped as delivered by the MAC).

Test Plan:
- Identity: A=I, B(r,c)=5r+c, behavioural MAC with L=6 -> mat_c==mat_b, ovf=0, err=0, done pulse exactly 175 edges after start; mac_en low for exactly one cycle between elements.
- Signed: A all 0xFF (-1), B all 0x02 -> every C element 0xF6 (-10), ovf_map=0.
- Overflow: A and B all 0x7F, MAC model asserts overflow -> ovf_map=25'h1FFFFFF, ovf=1; mat_c holds the MAC's wrapped values.
- Timeout: MAC model withholds done at element index 3 -> err=1 and done pulse after 16 WAIT cycles; C(0,0..2) valid, all other elements 0, mac_en=0 after FINISH.
- Reset mid-run: rst_n low during element 10 -> outputs zero immediately, no done pulse; a following start with the identity case completes correctly.
- Robustness: start pulses while busy ignored; mat_a changed to all 0x00 during the run -> results still match the snapshotted A.

Source files
------------

// File: rtl/matmul5_seq.sv
// matmul5_seq: matrix-level sequencer in front of the 8-bit signed MAC.
// Snapshots A and B, then walks C = A x B in row-major order. For each
// element it presents row i of A and column j of B to the MAC, waits for
// mac_done, and stores the result and overflow bit. A per-element watchdog
// aborts the run if the MAC never answers.
module matmul5_seq #(
    parameter int DIM     = 5,
    parameter int W       = 8,
    parameter int TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [DIM*DIM*W-1:0]   mat_a,
    input  logic [DIM*DIM*W-1:0]   mat_b,
    output logic [DIM*W-1:0]       mac_a,
    output logic [DIM*W-1:0]       mac_b,
    output logic                   mac_en,
    input  logic [W-1:0]           mac_result,
    input  logic                   mac_overflow,
    input  logic                   mac_done,
    output logic [DIM*DIM*W-1:0]   mat_c,
    output logic [DIM*DIM-1:0]     ovf_map,
    output logic                   ovf,
    output logic                   err,
    output logic                   busy,
    output logic                   done
);
    localparam int N  = DIM * DIM;
    localparam int IW = $clog2(DIM);
    localparam int EW = $clog2(N);
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, SETUP, WAIT, FINISH} state_t;

    state_t          state, state_nx;
    logic [N*W-1:0]  a_q, b_q;
    logic [IW-1:0]   i, j;
    logic [CW-1:0]   wdog;
    logic [EW-1:0]   elem;
    logic            last;
    logic            expired;

    assign elem    = EW'(i) * EW'(DIM) + EW'(j);
    assign last    = (i == IW'(DIM - 1)) && (j == IW'(DIM - 1));
    assign expired = (wdog == CW'(TIMEOUT - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state decode; control outputs are pure decode of the state
    always_comb begin
        state_nx = state;
        mac_en   = 1'b0;
        busy     = 1'b1;
        done     = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nx = SETUP;
            end
            SETUP: state_nx = WAIT;
            WAIT: begin
                mac_en = 1'b1;
                if (mac_done)     state_nx = last ? FINISH : SETUP;
                else if (expired) state_nx = FINISH;
            end
            FINISH: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Operand lanes come straight from the snapshots indexed by registered
    // (i,j); they only change in SETUP, so they are stable through WAIT.
    // Quiet (zero) whenever no element is in flight.
    always_comb begin
        mac_a = '0;
        mac_b = '0;
        if (state == SETUP || state == WAIT) begin
            for (int k = 0; k < DIM; k++) begin
                mac_a[k*W +: W] = a_q[W*(DIM*int'(i) + k) +: W];
                mac_b[k*W +: W] = b_q[W*(DIM*k + int'(j)) +: W];
            end
        end
    end

    // Datapath: snapshot, element walk, watchdog, result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            i       <= '0;
            j       <= '0;
            wdog    <= '0;
            mat_c   <= '0;
            ovf_map <= '0;
            ovf     <= 1'b0;
            err     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    a_q     <= mat_a;
                    b_q     <= mat_b;
                    i       <= '0;
                    j       <= '0;
                    mat_c   <= '0;
                    ovf_map <= '0;
                    ovf     <= 1'b0;
                    err     <= 1'b0;
                end
                SETUP: wdog <= '0;
                WAIT: begin
                    wdog <= wdog + 1'b1;
                    if (mac_done) begin
                        mat_c[elem*W +: W] <= mac_result;
                        ovf_map[elem]      <= mac_overflow;
                        // ovf tracks |ovf_map as it is built up
                        ovf                <= ovf | mac_overflow;
                        if (!last) begin
                            if (j == IW'(DIM - 1)) begin
                                j <= '0;
                                i <= i + 1'b1;
                            end else begin
                                j <= j + 1'b1;
                            end
                        end
                    end else if (expired) begin
                        err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_matmul5_seq.sv
// Bench for matmul5_seq: behavioural MAC (done on 6th enabled cycle),
// scoreboard of expected results pushed at start and popped at done.
module tb_matmul5_seq;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [199:0] mat_a, mat_b;
    logic [39:0]  mac_a, mac_b;
    logic         mac_en;
    logic [7:0]   mac_result;
    logic         mac_overflow;
    logic         mac_done;
    logic [199:0] mat_c;
    logic [24:0]  ovf_map;
    logic         ovf, err, busy, done;

    int total = 0;
    int bad   = 0;

    matmul5_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .mat_a(mat_a), .mat_b(mat_b),
        .mac_a(mac_a), .mac_b(mac_b), .mac_en(mac_en),
        .mac_result(mac_result), .mac_overflow(mac_overflow), .mac_done(mac_done),
        .mat_c(mat_c), .ovf_map(ovf_map), .ovf(ovf), .err(err),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Behavioural MAC: counts enabled cycles, done on the 6th one
    logic [3:0] mcnt;
    int         elem_cnt;
    int         hold_idx;
    logic       clr_model;
    int         ms;

    always @(posedge clk) begin
        if (!mac_en) mcnt <= '0;
        else         mcnt <= mcnt + 4'd1;
    end

    always @(posedge clk) begin
        if (clr_model)     elem_cnt <= 0;
        else if (mac_done) elem_cnt <= elem_cnt + 1;
    end

    always_comb begin
        ms = 0;
        for (int k = 0; k < 5; k++)
            ms += int'($signed(mac_a[8*k +: 8])) * int'($signed(mac_b[8*k +: 8]));
    end

    assign mac_result   = ms[7:0];
    assign mac_overflow = (ms > 127) || (ms < -128);
    assign mac_done     = mac_en && (mcnt == 4'd5) && (elem_cnt != hold_idx);

    typedef struct {
        logic [199:0] c;
        logic [24:0]  om;
        logic         o;
        logic         e;
        int           lat;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string tag, input logic [199:0] obs, input logic [199:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference multiply straight from the packed matrices
    function automatic void mm(input logic [199:0] a, input logic [199:0] b,
                               output logic [199:0] c, output logic [24:0] om);
        int s;
        c  = '0;
        om = '0;
        for (int r = 0; r < 5; r++)
            for (int q = 0; q < 5; q++) begin
                s = 0;
                for (int k = 0; k < 5; k++)
                    s += int'($signed(a[8*(5*r+k) +: 8])) * int'($signed(b[8*(5*k+q) +: 8]));
                c[8*(5*r+q) +: 8] = s[7:0];
                om[5*r+q]         = (s > 127) || (s < -128);
            end
    endfunction

    function automatic logic [199:0] fill(input logic [7:0] v);
        logic [199:0] m;
        for (int e = 0; e < 25; e++) m[8*e +: 8] = v;
        return m;
    endfunction

    // kind 0: identity, 1: B(r,c)=5r+c, 2: r+2c-3, 3: c-r+1
    function automatic logic [199:0] gen(input int kind);
        logic [199:0] m;
        int v;
        for (int r = 0; r < 5; r++)
            for (int q = 0; q < 5; q++) begin
                case (kind)
                    0:       v = (r == q) ? 1 : 0;
                    1:       v = 5*r + q;
                    2:       v = r + 2*q - 3;
                    default: v = q - r + 1;
                endcase
                m[8*(5*r+q) +: 8] = v[7:0];
            end
        return m;
    endfunction

    task automatic run(input string tag, input logic [199:0] a, input logic [199:0] b,
                       input int hold, input bit glitch);
        exp_t x, got;
        int n, lows;
        bit prev_en, gap;
        mm(a, b, x.c, x.om);
        if (hold >= 0)
            for (int e = hold; e < 25; e++) begin
                x.c[8*e +: 8] = 8'h00;
                x.om[e]       = 1'b0;
            end
        x.o   = |x.om;
        x.e   = (hold >= 0);
        x.lat = (hold >= 0) ? hold*7 + 17 : 175;
        sb.push_back(x);

        hold_idx  = hold;
        clr_model = 1'b1;
        mat_a     = a;
        mat_b     = b;
        start     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clr_model = 1'b0;
        start     = 1'b0;
        n = 0; lows = 0; prev_en = 1'b1; gap = 1'b0;
        if (busy && !mac_en) begin lows++; prev_en = 1'b0; end
        while (!done && n < 400) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (busy && !done) begin
                if (!mac_en) begin
                    lows++;
                    if (!prev_en) gap = 1'b1;
                end
                prev_en = mac_en;
            end
            if (glitch) begin
                start = (n == 20 || n == 50);
                if (n == 30) mat_a = '0;
            end
        end
        chk({tag, "_done_seen"}, 200'(done), 200'(1'b1));
        got = sb.pop_front();
        chk({tag, "_latency"}, 200'(n), 200'(got.lat));
        chk({tag, "_mat_c"}, mat_c, got.c);
        chk({tag, "_ovf_map"}, 200'(ovf_map), 200'(got.om));
        chk({tag, "_ovf"}, 200'(ovf), 200'(got.o));
        chk({tag, "_err"}, 200'(err), 200'(got.e));
        chk({tag, "_busy_finish"}, 200'(busy), 200'(1'b1));
        chk({tag, "_en_lows"}, 200'(lows), 200'((hold >= 0) ? hold + 1 : 25));
        chk({tag, "_en_gap1"}, 200'(gap), 200'(1'b0));
        // start during FINISH must be ignored
        if (glitch) start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_idle_busy"}, 200'(busy), 200'(1'b0));
        chk({tag, "_idle_done"}, 200'(done), 200'(1'b0));
        chk({tag, "_idle_en"}, 200'(mac_en), 200'(1'b0));
        repeat (3) @(negedge clk);
        chk({tag, "_hold_ovf"}, 200'(ovf), 200'(got.o));
        chk({tag, "_hold_err"}, 200'(err), 200'(got.e));
        chk({tag, "_hold_c"}, mat_c, got.c);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_mat_c"}, mat_c, '0);
        chk({tag, "_ovf_map"}, 200'(ovf_map), '0);
        chk({tag, "_ovf"}, 200'(ovf), '0);
        chk({tag, "_err"}, 200'(err), '0);
        chk({tag, "_busy"}, 200'(busy), '0);
        chk({tag, "_done"}, 200'(done), '0);
        chk({tag, "_mac_en"}, 200'(mac_en), '0);
        chk({tag, "_mac_a"}, 200'(mac_a), '0);
        chk({tag, "_mac_b"}, 200'(mac_b), '0);
    endtask

    initial begin
        logic [199:0] ident, ramp, ones_ovf;
        int n;
        bit saw_done;
        ident     = gen(0);
        ramp      = gen(1);
        rst_n     = 1'b0;
        start     = 1'b0;
        clr_model = 1'b1;
        hold_idx  = -1;
        mat_a     = '0;
        mat_b     = '0;
        #1;
        chk_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Identity: C must equal B
        run("ident", ident, ramp, -1, 1'b0);
        chk("ident_c_eq_b", mat_c, ramp);

        // Signed: -1 * 2 summed five times
        run("signed", fill(8'hFF), fill(8'h02), -1, 1'b0);
        chk("signed_all_f6", mat_c, fill(8'hF6));

        // Overflow everywhere
        run("ovf", fill(8'h7F), fill(8'h7F), -1, 1'b0);
        ones_ovf = 200'(25'h1FFFFFF);
        chk("ovf_all_set", 200'(ovf_map), ones_ovf);

        // MAC never answers element 3
        run("tmo", ramp, ident, 3, 1'b0);

        // Reset in the middle of element 10
        hold_idx  = -1;
        clr_model = 1'b1;
        mat_a     = ident;
        mat_b     = ramp;
        start     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clr_model = 1'b0;
        start     = 1'b0;
        saw_done  = 1'b0;
        n = 0;
        while (n < 72) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        chk("midrst_pre_busy", 200'(busy), 200'(1'b1));
        rst_n = 1'b0;
        #1;
        chk_zero("midrst");
        repeat (3) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        chk("midrst_no_done", 200'(saw_done), 200'(1'b0));
        rst_n = 1'b1;
        @(negedge clk);
        run("post_rst", ident, ramp, -1, 1'b0);

        // Start pulses while busy, A cleared mid-run
        run("robust", gen(2), gen(3), -1, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
